alu_share_arbiter: RTL and testbench

- Shares one single-cycle ALU (8-bit A/B, 3-bit op, registered 16-bit result, one-cycle done pulse) between two requesters.
- Arbitrates round-robin, drives ALU start/op/operands, holds start until done, captures the result and returns it to the winner.
- Filters illegal ops and times out a hung ALU.
- Sits between bus-side command agents and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one single-cycle ALU between two requesters.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   reqN_valid/ready/op/a/b              command handshake (ready is combinational)
//   rspN_valid/result/err                one-cycle response pulse plus held payload
//   alu_start/op/A/B                     ALU command, start held for the whole RUN
//   alu_done/result                      ALU completion pulse and registered result
module alu_share_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned D_W   = 8;
  localparam int unsigned R_W   = 16;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  // Requester whose illegal-op response pulse is in flight; it may not win that cycle.
  logic [1:0]       blk_q, blk_d;

  logic             alu_start_d;
  logic [OP_W-1:0]  alu_op_d;
  logic [D_W-1:0]   alu_a_d, alu_b_d;
  logic             rsp0_valid_d, rsp1_valid_d;
  logic             rsp0_err_d, rsp1_err_d;
  logic [R_W-1:0]   rsp0_result_d, rsp1_result_d;

  logic             elig0_c, elig1_c, grant0_c, grant1_c;
  logic             accept_c, sel_c, legal_c;
  logic [OP_W-1:0]  cmd_op_c;
  logic [D_W-1:0]   cmd_a_c, cmd_b_c;

  // Round-robin grant: on contention the requester that did not win last goes next.
  always_comb begin
    elig0_c  = req0_valid && !blk_q[0];
    elig1_c  = req1_valid && !blk_q[1];
    grant0_c = elig0_c && (!elig1_c || last_grant_q);
    grant1_c = elig1_c && (!elig0_c || !last_grant_q);
  end

  assign req0_ready = (state_q == IDLE) && grant0_c;
  assign req1_ready = (state_q == IDLE) && grant1_c;

  // Command mux toward the ALU and opcode legality (add, and, xor only).
  always_comb begin
    accept_c = req0_ready || req1_ready;
    sel_c    = req1_ready;
    cmd_op_c = sel_c ? req1_op : req0_op;
    cmd_a_c  = sel_c ? req1_a  : req0_a;
    cmd_b_c  = sel_c ? req1_b  : req0_b;
    legal_c  = (cmd_op_c == 3'd1) || (cmd_op_c == 3'd2) || (cmd_op_c == 3'd3);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    blk_d         = 2'b00;
    alu_start_d   = alu_start;
    alu_op_d      = alu_op;
    alu_a_d       = alu_A;
    alu_b_d       = alu_B;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_err_d    = rsp0_err;
    rsp1_err_d    = rsp1_err;
    rsp0_result_d = rsp0_result;
    rsp1_result_d = rsp1_result;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          last_grant_d = sel_c;
          if (legal_c) begin
            alu_op_d    = cmd_op_c;
            alu_a_d     = cmd_a_c;
            alu_b_d     = cmd_b_c;
            alu_start_d = 1'b1;
            cnt_d       = '0;
            owner_d     = sel_c;
            state_d     = RUN;
          end else if (sel_c) begin
            rsp1_valid_d  = 1'b1;
            rsp1_err_d    = 1'b1;
            rsp1_result_d = '0;
            blk_d[1]      = 1'b1;
          end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_err_d    = 1'b1;
            rsp0_result_d = '0;
            blk_d[0]      = 1'b1;
          end
        end
      end

      RUN: begin
        if (alu_done) begin
          alu_start_d = 1'b0;
          state_d     = IDLE;
          if (owner_q) begin
            rsp1_valid_d  = 1'b1;
            rsp1_err_d    = 1'b0;
            rsp1_result_d = alu_result;
          end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_err_d    = 1'b0;
            rsp0_result_d = alu_result;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          alu_start_d = 1'b0;
          state_d     = IDLE;
          if (owner_q) begin
            rsp1_valid_d  = 1'b1;
            rsp1_err_d    = 1'b1;
            rsp1_result_d = '0;
          end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_err_d    = 1'b1;
            rsp0_result_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers; reset drops any in-flight op silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      blk_q        <= 2'b00;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_err     <= 1'b0;
      rsp1_err     <= 1'b0;
      rsp0_result  <= '0;
      rsp1_result  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      blk_q        <= blk_d;
      alu_start    <= alu_start_d;
      alu_op       <= alu_op_d;
      alu_A        <= alu_a_d;
      alu_B        <= alu_b_d;
      rsp0_valid   <= rsp0_valid_d;
      rsp1_valid   <= rsp1_valid_d;
      rsp0_err     <= rsp0_err_d;
      rsp1_err     <= rsp1_err_d;
      rsp0_result  <= rsp0_result_d;
      rsp1_result  <= rsp1_result_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural single-cycle ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result;
  logic        alu_start, alu_done;
  logic [2:0]  alu_op;
  logic [7:0]  alu_A, alu_B;
  logic [15:0] alu_result;

  logic        m_done = 1'b0;
  logic [15:0] m_res = '0;
  logic        stuck = 1'b0;
  logic        spur = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  // Conforming ALU: one-cycle done pulse per start, result registered with done.
  always @(posedge clk) begin
    if (alu_start && !m_done && !stuck) begin
      m_done <= 1'b1;
      case (alu_op)
        3'd1:    m_res <= 16'(alu_A) + 16'(alu_B);
        3'd2:    m_res <= 16'(alu_A & alu_B);
        3'd3:    m_res <= 16'(alu_A ^ alu_B);
        default: m_res <= 16'h0000;
      endcase
    end else begin
      m_done <= 1'b0;
    end
  end

  assign alu_done   = m_done | spur;
  assign alu_result = m_res;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL rst_alu_start got %0h exp 0", alu_start); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b%0b exp 00", rsp1_valid, rsp0_valid); end
    checks++; if (alu_op !== 3'd0 || alu_A !== 8'd0 || alu_B !== 8'd0) begin errors++; $display("FAIL rst_alu_fields got %0h/%0h/%0h exp 0", alu_op, alu_A, alu_B); end
    checks++; if (rsp0_result !== 16'h0 || rsp1_result !== 16'h0) begin errors++; $display("FAIL rst_rsp_result got %0h/%0h exp 0", rsp0_result, rsp1_result); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    req0_op = 3'd1; req0_a = 8'hFF; req0_b = 8'h01; req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready got %0b%0b exp 01", req1_ready, req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (alu_start !== 1'b1 || alu_op !== 3'd1 || alu_A !== 8'hFF || alu_B !== 8'h01) begin errors++; $display("FAIL add_launch got %0b %0h %0h %0h exp 1 1 ff 01", alu_start, alu_op, alu_A, alu_B); end
    tick();
    checks++; if (alu_start !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_e1 got start %0b rsp %0b exp 1 0", alu_start, rsp0_valid); end
    tick();
    checks++; if (alu_start !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_result !== 16'h0100 || rsp0_err !== 1'b0) begin errors++; $display("FAIL add_rsp got %0b %0b %0h %0b exp 0 1 0100 0", alu_start, rsp0_valid, rsp0_result, rsp0_err); end
    tick();
    checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 16'h0100) begin errors++; $display("FAIL add_pulse_end got %0b %0h exp 0 0100", rsp0_valid, rsp0_result); end
  endtask

  task automatic test_round_robin();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req0_op = 3'd2; req0_a = 8'hF0; req0_b = 8'h3C; req0_valid = 1'b1;
    req1_op = 3'd3; req1_a = 8'hAA; req1_b = 8'h55; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rr_first got %0b%0b exp 01", req1_ready, req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (alu_op !== 3'd2 || alu_start !== 1'b1) begin errors++; $display("FAIL rr_launch0 got %0h %0b exp 2 1", alu_op, alu_start); end
    tick(); tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0030) begin errors++; $display("FAIL rr_rsp0 got %0b %0h exp 1 0030", rsp0_valid, rsp0_result); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rr_ready1 got %0b exp 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    checks++; if (alu_op !== 3'd3 || alu_A !== 8'hAA || alu_B !== 8'h55) begin errors++; $display("FAIL rr_launch1 got %0h %0h %0h exp 3 aa 55", alu_op, alu_A, alu_B); end
    tick(); tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 16'h00FF || rsp1_err !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp1 got %0b %0h %0b r0v %0b exp 1 00ff 0 0", rsp1_valid, rsp1_result, rsp1_err, rsp0_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rr_second got %0b%0b exp 01", req1_ready, req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0030) begin errors++; $display("FAIL rr_rsp0b got %0b %0h exp 1 0030", rsp0_valid, rsp0_result); end
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 16'h00FF) begin errors++; $display("FAIL rr_rsp1b got %0b %0h exp 1 00ff", rsp1_valid, rsp1_result); end
  endtask

  task automatic test_illegal_op();
    req1_op = 3'd0; req1_a = 8'h12; req1_b = 8'h34; req1_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %0b exp 1", req1_ready); end
    tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_result !== 16'h0000) begin errors++; $display("FAIL ill_rsp got %0b %0b %0h exp 1 1 0000", rsp1_valid, rsp1_err, rsp1_result); end
    checks++; if (alu_start !== 1'b0 || alu_op !== 3'd3 || alu_A !== 8'hAA) begin errors++; $display("FAIL ill_alu got %0b %0h %0h exp 0 3 aa", alu_start, alu_op, alu_A); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL ill_block got %0b exp 0", req1_ready); end
    req1_valid = 1'b0;
    tick();
    checks++; if (rsp1_valid !== 1'b0 || rsp1_err !== 1'b1 || alu_start !== 1'b0) begin errors++; $display("FAIL ill_after got %0b %0b %0b exp 0 1 0", rsp1_valid, rsp1_err, alu_start); end
  endtask

  task automatic test_timeout();
    int cnt;
    stuck = 1'b1;
    req0_op = 3'd3; req0_a = 8'h0F; req0_b = 8'hF0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    cnt = 0;
    while (alu_start === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++; if (cnt != 15) begin errors++; $display("FAIL to_start_cycles got %0d exp 15", cnt); end
    checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_result !== 16'h0000) begin errors++; $display("FAIL to_rsp got %0b %0b %0h exp 1 1 0000", rsp0_valid, rsp0_err, rsp0_result); end
    stuck = 1'b0;
    req0_op = 3'd1; req0_a = 8'h07; req0_b = 8'h08; req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL to_idle_ready got %0b exp 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h000F || rsp0_err !== 1'b0) begin errors++; $display("FAIL to_recover got %0b %0h %0b exp 1 000f 0", rsp0_valid, rsp0_result, rsp0_err); end
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_start !== 1'b0) begin errors++; $display("FAIL spur_done got %0b %0b %0b exp 0 0 0", rsp0_valid, rsp1_valid, alu_start); end
  endtask

  task automatic test_reset_in_run();
    logic seen;
    req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL rr_run_start got %0b exp 1", alu_start); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (alu_start !== 1'b0 || rsp0_valid !== 1'b0 || alu_A !== 8'h00 || alu_op !== 3'd0) begin errors++; $display("FAIL rst_run_async got %0b %0b %0h %0h exp 0 0 0 0", alu_start, rsp0_valid, alu_A, alu_op); end
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_start !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_run_no_rsp got %0b exp 0", seen); end
    req1_op = 3'd2; req1_a = 8'h0F; req1_b = 8'hFF;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_run_grant got %0b%0b exp 01", req1_ready, req0_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0033) begin errors++; $display("FAIL rst_run_op got %0b %0h exp 1 0033", rsp0_valid, rsp0_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [15:0] tr [3];
    logic        seen1;
    ta[0] = 8'h01; tb[0] = 8'h02; tr[0] = 16'h0003;
    ta[1] = 8'h80; tb[1] = 8'h80; tr[1] = 16'h0100;
    ta[2] = 8'hFF; tb[2] = 8'hFF; tr[2] = 16'h01FE;
    seen1 = 1'b0;
    req1_valid = 1'b0;
    req0_op = 3'd1; req0_a = ta[0]; req0_b = tb[0]; req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0b exp 1", req0_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp1_valid !== 1'b0) seen1 = 1'b1;
      if (k < 2) begin
        req0_a = ta[k+1]; req0_b = tb[k+1];
      end else begin
        req0_valid = 1'b0;
      end
      checks++; if (alu_A !== ta[k] || alu_B !== tb[k]) begin errors++; $display("FAIL b2b_launch%0d got %0h %0h exp %0h %0h", k, alu_A, alu_B, ta[k], tb[k]); end
      tick();
      if (rsp1_valid !== 1'b0) seen1 = 1'b1;
      checks++; if (alu_A !== ta[k] || alu_B !== tb[k] || req0_ready !== 1'b0) begin errors++; $display("FAIL b2b_stable%0d got %0h %0h rdy %0b exp %0h %0h 0", k, alu_A, alu_B, req0_ready, ta[k], tb[k]); end
      tick();
      if (rsp1_valid !== 1'b0) seen1 = 1'b1;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== tr[k]) begin errors++; $display("FAIL b2b_rsp%0d got %0b %0h exp 1 %0h", k, rsp0_valid, rsp0_result, tr[k]); end
      if (k < 2) begin
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_reready%0d got %0b exp 1", k, req0_ready); end
      end
    end
    checks++; if (seen1 !== 1'b0) begin errors++; $display("FAIL b2b_rsp1_idle got %0b exp 0", seen1); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_illegal_op();
    test_timeout();
    test_reset_in_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
